ram1_ctrl: RTL and testbench
============================

# ram1_ctrl

Sequential front-end for the `ram1` SRAM port. It arbitrates between the instruction-fetch (IF) and data-memory (MEM) requesters of the CPU and runs each access as a multi-cycle transaction. While a transaction runs it holds address, write data and direction registered and stable. Its outputs drive `ram1` directly, and `ram1` turns `clk` into the OE/WE strobes; the returned `Ram1Data` value feeds back into this block's `ram_rdata`.

## Interface
- `WAIT_CYCLES`, default 1: number of ACCESS cycles per transaction (legal range 1..7).
- `clk` in 1: system clock, also the `ram1` strobe. All state changes occur on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: IF read request, level, held until `if_done`.
- `if_addr` in 18: IF word address.
- `if_rdata` out 16: last IF read data.
- `if_done` out 1: one-cycle pulse when an IF access completes.
- `mem_req` in 1: MEM request, level, held until `mem_done`.
- `mem_we` in 1: 1 = write, 0 = read.
- `mem_addr` in 18: MEM word address.
- `mem_wdata` in 16: MEM write data.
- `mem_rdata` out 16: last MEM read data.
- `mem_done` out 1: one-cycle pulse when a MEM access completes.
- `stall` out 1: asserted when a request is pending but is not completing this cycle. Pipeline freeze.
- `ram_addr` out 18: to `ram1.addr`.
- `ram_wdata` out 16: to `ram1.data`.
- `ram_write` out 1: to `ram1.read`; 0 = read, 1 = write.
- `ram_rdata` in 16: from the `Ram1Data` bus.

## Operation
- States:
  - IDLE: no transaction.
  - ACCESS: a transaction is driving the SRAM.
  - DONE: the transaction has finished and the done pulse is issued.
- A 3-bit wait counter runs in ACCESS.
- IDLE:
  - If `mem_req` or `if_req` is high, grant one requester. Grant is fixed priority, MEM over IF, unless the macro below is defined.
  - On grant, latch the granted address into `ram_addr`. Latch `mem_wdata` into `ram_wdata`. Set `ram_write` = `mem_we` for a MEM grant, or 0 for an IF grant.
  - Clear the counter, record the grantee, and go to ACCESS.
- ACCESS:
  - `ram_addr`, `ram_wdata` and `ram_write` are held constant.
  - The counter increments each cycle.
  - On the edge ending cycle `WAIT_CYCLES`, a read captures `ram_rdata` into the grantee's rdata register and the block goes to DONE.
- DONE:
  - The grantee's done output is high for exactly this cycle.
  - `ram_write` returns to 0 on entering DONE.
  - The next state is IDLE.
  - The other requester's pending request is not granted in DONE.
- Requesters drop `req` in the cycle after done. If `req` is still high in IDLE, it is a new request.
- A write never alters either rdata register.
- `stall` = (`if_req` & !`if_done`) | (`mem_req` & !`mem_done`), combinational from registered state and the inputs.
- A request arriving during ACCESS or DONE waits; it is only sampled in IDLE.
- Inputs are don't-care outside IDLE because the granted address and data are latched at grant.

## Timing
- Reset value of every output is 0: `ram_addr`, `ram_wdata`, `ram_write` (idle read, harmless), both rdata registers, both done pulses and `stall` (given requests low). State resets to IDLE and the counter to 0.
- Reset asserted mid-transaction aborts it:
  - No done pulse is issued.
  - rdata keeps the reset value.
  - `ram_write` drops to 0 immediately (asynchronous).
- Latency from a request seen in IDLE at edge t to the done pulse is `WAIT_CYCLES`+1 cycles. With the default, done is high in cycle t+2.
- Transaction period is `WAIT_CYCLES`+2 cycles, so back-to-back throughput is one access per 3 cycles by default.
- SRAM strobes occur in the low half of each ACCESS cycle. Address, data and direction change only on rising edges, so they are stable across every strobe.
- Read data is sampled at the rising edge that ends the last low phase.
- A write with `WAIT_CYCLES` > 1 pulses WE repeatedly with identical address and data. This is permitted.

## Configuration
- Macro `RAM1_CTRL_RR_ARB_EN`.
- When defined:
  - Arbitration is round-robin with a 1-bit last-grant register, reset value IF.
  - On simultaneous requests, the requester not granted last wins.
- When undefined:
  - Arbitration is fixed MEM-over-IF. IF can starve under continuous MEM traffic.
  - No last-grant register exists.

## Test plan
- Reset: `rst`=0 for 2 cycles, then release with both requests low. All outputs are 0 and the state is IDLE.
- IF read: `if_req`=1, `if_addr`=18'h00010, SRAM model returns 16'hBEEF. `if_done` pulses in cycle t+2 and `if_rdata`=16'hBEEF. `ram_write`=0 throughout and `stall`=1 in t..t+1.
- MEM write then read:
  - Write `mem_we`=1, `mem_addr`=18'h00200, `mem_wdata`=16'h1234. `ram_write`=1 during ACCESS only and `mem_done` pulses.
  - Then read the same address. `mem_rdata`=16'h1234 and `if_rdata` is unchanged.
- Simultaneous requests, IF addr 18'h1 and MEM addr 18'h2, both held:
  - Without the macro, MEM is served first (`mem_done` at t+2), then IF (`if_done` at t+5).
  - With `RAM1_CTRL_RR_ARB_EN`, the order alternates on repeated collisions.
- Reset mid-ACCESS of a MEM read. No `mem_done` pulse, `mem_rdata` stays 0, `ram_write` is 0 at once, and a new request after release completes normally.
- `WAIT_CYCLES`=3, IF read of 16'hA5A5. `if_done` pulses 4 cycles after the request and `ram_addr` is stable for all 3 ACCESS cycles.

Source files
------------

// File: rtl/ram1_ctrl_if.sv
// ram1_ctrl_if: CPU requester and ram1 SRAM signals of the ram1_ctrl front-end.
//   master : CPU requesters plus the SRAM read-data return (test/system side)
//   slave  : ram1_ctrl itself
//   IF  side : if_req, if_addr -> if_rdata, if_done
//   MEM side : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_done
//   stall    : pipeline freeze, combinational
//   SRAM     : ram_addr, ram_wdata, ram_write out; ram_rdata in
interface ram1_ctrl_if;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          stall;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_write;
    logic [DW-1:0] ram_rdata;

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_done, mem_rdata, mem_done, stall,
               ram_addr, ram_wdata, ram_write
    );

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_done, mem_rdata, mem_done, stall,
               ram_addr, ram_wdata, ram_write
    );
endinterface

// File: rtl/ram1_ctrl.sv
// ram1_ctrl: sequential front-end for the ram1 SRAM port. Arbitrates between the
// instruction-fetch (IF) and data-memory (MEM) requesters and runs each access as
// an IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE transaction with address, write
// data and direction registered and held for the whole transaction.
//   clk : system clock, also the ram1 strobe source
//   rst : asynchronous active-low reset
//   bus : ram1_ctrl_if.slave (requester ports, stall, SRAM ports)
// Optional feature: define RAM1_CTRL_RR_ARB_EN for round-robin arbitration
// (default build is fixed MEM-over-IF priority).
module ram1_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    ram1_ctrl_if.slave  bus
);
    localparam int unsigned AW    = 18;
    localparam int unsigned DW    = 16;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        G_IF  = 1'b0,
        G_MEM = 1'b1
    } grant_e;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    grant_e           gnt_q,       gnt_d;
    logic [AW-1:0]    addr_q,      addr_d;
    logic [DW-1:0]    wdata_q,     wdata_d;
    logic             write_q,     write_d;
    logic [DW-1:0]    if_rdata_q,  if_rdata_d;
    logic [DW-1:0]    mem_rdata_q, mem_rdata_d;
    logic             if_done_q,   if_done_d;
    logic             mem_done_q,  mem_done_d;
    logic             pick_mem;
    logic             last_cyc;

`ifdef RAM1_CTRL_RR_ARB_EN
    grant_e           last_q,      last_d;

    // On a collision the requester not granted last wins
    always_comb begin
        pick_mem = bus.mem_req;
        if (bus.mem_req && bus.if_req) begin
            pick_mem = (last_q == G_IF);
        end
    end
`else
    // Fixed MEM-over-IF priority
    always_comb begin
        pick_mem = bus.mem_req;
    end
`endif

    assign last_cyc = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
`ifdef RAM1_CTRL_RR_ARB_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_req || bus.if_req) begin
                    gnt_d   = pick_mem ? G_MEM : G_IF;
                    addr_d  = pick_mem ? bus.mem_addr : bus.if_addr;
                    wdata_d = bus.mem_wdata;
                    write_d = pick_mem & bus.mem_we;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
`ifdef RAM1_CTRL_RR_ARB_EN
                    last_d  = pick_mem ? G_MEM : G_IF;
`endif
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_cyc) begin
                    // Reads sample ram_rdata at the edge ending the last low phase
                    if (!write_q) begin
                        if (gnt_q == G_MEM) mem_rdata_d = bus.ram_rdata;
                        else                if_rdata_d  = bus.ram_rdata;
                    end
                    if (gnt_q == G_MEM) mem_done_d = 1'b1;
                    else                if_done_d  = 1'b1;
                    write_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gnt_q       <= G_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
`ifdef RAM1_CTRL_RR_ARB_EN
            last_q      <= G_IF;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
`ifdef RAM1_CTRL_RR_ARB_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_write = write_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.mem_done  = mem_done_q;

    // Freeze the pipeline while any request is pending and not completing now
    assign bus.stall = (bus.if_req & ~if_done_q) | (bus.mem_req & ~mem_done_q);

endmodule

// File: tb/tb_ram1_ctrl.sv
// tb_ram1_ctrl: directed scoreboard bench for ram1_ctrl (WAIT_CYCLES 1 and 3).
module tb_ram1_ctrl;
    typedef struct {
        logic [15:0] data;
        logic        chk_data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   last_mem = 1'b0;

    exp_t q_if1[$];
    exp_t q_mem1[$];
    exp_t q_if3[$];

    logic [15:0] sram1 [logic [17:0]];
    logic [15:0] sram3 [logic [17:0]];

    ram1_ctrl_if b1();
    ram1_ctrl_if b3();

    ram1_ctrl #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    ram1_ctrl #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: write strobe and read data in the low half of the cycle
    always @(negedge clk) begin
        if (b1.ram_write) sram1[b1.ram_addr] = b1.ram_wdata;
        b1.ram_rdata = sram1.exists(b1.ram_addr) ? sram1[b1.ram_addr] : 16'h0;
    end
    always @(negedge clk) begin
        if (b3.ram_write) sram3[b3.ram_addr] = b3.ram_wdata;
        b3.ram_rdata = sram3.exists(b3.ram_addr) ? sram3[b3.ram_addr] : 16'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop the expected completion whenever a done pulse appears
    always @(negedge clk) begin
        exp_t e;
        if (b1.if_done) begin
            if (q_if1.size() == 0) chk("if1_unexpected_done", 1, 0);
            else begin
                e = q_if1.pop_front();
                chk("if1_done_cycle", cyc, e.cyc);
                if (e.chk_data) chk("if1_rdata", {16'h0, b1.if_rdata}, {16'h0, e.data});
            end
        end
        if (b1.mem_done) begin
            if (q_mem1.size() == 0) chk("mem1_unexpected_done", 1, 0);
            else begin
                e = q_mem1.pop_front();
                chk("mem1_done_cycle", cyc, e.cyc);
                if (e.chk_data) chk("mem1_rdata", {16'h0, b1.mem_rdata}, {16'h0, e.data});
            end
        end
        if (b3.if_done) begin
            if (q_if3.size() == 0) chk("if3_unexpected_done", 1, 0);
            else begin
                e = q_if3.pop_front();
                chk("if3_done_cycle", cyc, e.cyc);
                if (e.chk_data) chk("if3_rdata", {16'h0, b3.if_rdata}, {16'h0, e.data});
            end
        end
    end

    task automatic push_if1(input logic [15:0] d, input int lat);
        exp_t e;
        e.data = d; e.chk_data = 1'b1; e.cyc = cyc + lat;
        q_if1.push_back(e);
    endtask

    task automatic push_mem1(input logic [15:0] d, input logic c, input int lat);
        exp_t e;
        e.data = d; e.chk_data = c; e.cyc = cyc + lat;
        q_mem1.push_back(e);
    endtask

    // Bounded wait for a done pulse on dut1, then drop that request
    task automatic wait_done(input bit is_mem);
        int n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (is_mem ? b1.mem_done : b1.if_done) break;
            n++;
        end
        if (n >= 20) chk(is_mem ? "mem_done_timeout" : "if_done_timeout", 0, 1);
        @(posedge clk); #1;
        if (is_mem) b1.mem_req = 1'b0;
        else        b1.if_req  = 1'b0;
    endtask

    // Both requesters at once: IF addr 1 (16'h1111), MEM addr 2 (16'h2222)
    task automatic collide();
        bit mem_first;
`ifdef RAM1_CTRL_RR_ARB_EN
        mem_first = !last_mem;
`else
        mem_first = 1'b1;
`endif
        @(posedge clk); #1;
        b1.if_addr = 18'h1; b1.mem_addr = 18'h2; b1.mem_we = 1'b0;
        b1.if_req = 1'b1; b1.mem_req = 1'b1;
        push_if1(16'h1111, mem_first ? 5 : 2);
        push_mem1(16'h2222, 1'b1, mem_first ? 2 : 5);
        if (mem_first) begin wait_done(1'b1); wait_done(1'b0); end
        else           begin wait_done(1'b0); wait_done(1'b1); end
        last_mem = !mem_first;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.if_req = 0; b1.if_addr = '0; b1.mem_req = 0; b1.mem_we = 0;
        b1.mem_addr = '0; b1.mem_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.mem_req = 0; b3.mem_we = 0;
        b3.mem_addr = '0; b3.mem_wdata = '0;
        sram1[18'h10] = 16'hBEEF;
        sram1[18'h1]  = 16'h1111;
        sram1[18'h2]  = 16'h2222;
        sram3[18'h40] = 16'hA5A5;

        // Reset: two cycles low, release with requests low
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ram_addr",  {14'h0, b1.ram_addr}, 32'h0);
        chk("rst_ram_wdata", {16'h0, b1.ram_wdata}, 32'h0);
        chk("rst_ram_write", {31'h0, b1.ram_write}, 32'h0);
        chk("rst_if_rdata",  {16'h0, b1.if_rdata}, 32'h0);
        chk("rst_mem_rdata", {16'h0, b1.mem_rdata}, 32'h0);
        chk("rst_dones",     {30'h0, b1.if_done, b1.mem_done}, 32'h0);
        chk("rst_stall",     {31'h0, b1.stall}, 32'h0);

        // IF read of 16'hBEEF at 18'h00010
        @(posedge clk); #1;
        b1.if_addr = 18'h00010; b1.if_req = 1'b1; push_if1(16'hBEEF, 2); last_mem = 1'b0;
        #1 chk("ifrd_stall_t", {31'h0, b1.stall}, 32'h1);
        chk("ifrd_write_t", {31'h0, b1.ram_write}, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("ifrd_stall_t1", {31'h0, b1.stall}, 32'h1);
        chk("ifrd_write_t1", {31'h0, b1.ram_write}, 32'h0);
        chk("ifrd_addr_t1",  {14'h0, b1.ram_addr}, 32'h10);
        @(negedge clk);
        chk("ifrd_stall_done", {31'h0, b1.stall}, 32'h0);
        chk("ifrd_write_done", {31'h0, b1.ram_write}, 32'h0);
        @(posedge clk); #1 b1.if_req = 1'b0;

        // MEM write 16'h1234 to 18'h00200
        @(posedge clk); #1;
        b1.mem_we = 1'b1; b1.mem_addr = 18'h00200; b1.mem_wdata = 16'h1234; b1.mem_req = 1'b1;
        push_mem1(16'h0, 1'b0, 2); last_mem = 1'b1;
        @(negedge clk);
        chk("wr_write_idle", {31'h0, b1.ram_write}, 32'h0);
        @(negedge clk);
        chk("wr_write_access", {31'h0, b1.ram_write}, 32'h1);
        chk("wr_addr_access",  {14'h0, b1.ram_addr}, 32'h200);
        chk("wr_wdata_access", {16'h0, b1.ram_wdata}, 32'h1234);
        @(negedge clk);
        chk("wr_write_done", {31'h0, b1.ram_write}, 32'h0);
        chk("wr_mem_rdata_kept", {16'h0, b1.mem_rdata}, 32'h0);
        @(posedge clk); #1 b1.mem_req = 1'b0; b1.mem_we = 1'b0;

        // MEM read back; IF rdata must be untouched
        @(posedge clk); #1;
        b1.mem_req = 1'b1; push_mem1(16'h1234, 1'b1, 2); last_mem = 1'b1;
        wait_done(1'b1);
        chk("rd_if_rdata_kept", {16'h0, b1.if_rdata}, 32'hBEEF);

        // Repeated collisions
        collide();
        collide();

        // Reset in the ACCESS cycle of a MEM write: ram_write drops at once
        @(posedge clk); #1;
        b1.mem_we = 1'b1; b1.mem_addr = 18'h00300; b1.mem_wdata = 16'h5555; b1.mem_req = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("abw_write_before", {31'h0, b1.ram_write}, 32'h1);
        rst = 1'b0; b1.mem_req = 1'b0; b1.mem_we = 1'b0;
        #1 chk("abw_write_async", {31'h0, b1.ram_write}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; last_mem = 1'b0;

        // Reset in the ACCESS cycle of a MEM read: no done, rdata stays 0
        @(posedge clk); #1;
        b1.mem_addr = 18'h00200; b1.mem_req = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; b1.mem_req = 1'b0;
        #1 chk("abr_write_async", {31'h0, b1.ram_write}, 32'h0);
        chk("abr_no_done", {31'h0, b1.mem_done}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; last_mem = 1'b0;
        repeat (3) @(negedge clk);
        chk("abr_mem_rdata_zero", {16'h0, b1.mem_rdata}, 32'h0);

        // New request after release completes normally
        @(posedge clk); #1;
        b1.mem_req = 1'b1; push_mem1(16'h1234, 1'b1, 2); last_mem = 1'b1;
        wait_done(1'b1);

        // WAIT_CYCLES=3: IF read of 16'hA5A5, address stable over 3 ACCESS cycles
        @(posedge clk); #1;
        b3.if_addr = 18'h40; b3.if_req = 1'b1;
        begin
            exp_t e;
            e.data = 16'hA5A5; e.chk_data = 1'b1; e.cyc = cyc + 4;
            q_if3.push_back(e);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("w3_addr_stable", {14'h0, b3.ram_addr}, 32'h40);
        end
        @(negedge clk);
        chk("w3_done_cycle4", {31'h0, b3.if_done}, 32'h1);
        @(posedge clk); #1 b3.if_req = 1'b0;

        repeat (4) @(posedge clk);
        chk("sb_if1_empty",  q_if1.size(), 0);
        chk("sb_mem1_empty", q_mem1.size(), 0);
        chk("sb_if3_empty",  q_if3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
